// File: rtl/traffic_pkg.sv
// Shared state encodings, lamp codes and the Moore lamp decode for the
// two-road traffic light controller.
package traffic_pkg;

   typedef enum logic [2:0] {
      ST_MAIN_GREEN  = 3'd0,
      ST_MAIN_YELLOW = 3'd1,
      ST_ALL_RED_1   = 3'd2,
      ST_SIDE_GREEN  = 3'd3,
      ST_SIDE_YELLOW = 3'd4,
      ST_ALL_RED_2   = 3'd5,
      ST_FLASH       = 3'd6
   } state_e;

   localparam logic [2:0] LAMP_R   = 3'b100;
   localparam logic [2:0] LAMP_Y   = 3'b010;
   localparam logic [2:0] LAMP_G   = 3'b001;
   localparam logic [2:0] LAMP_OFF = 3'b000;

   typedef struct packed {
      logic [2:0] main;
      logic [2:0] side;
      logic       walk;
   } lamps_t;

   function automatic lamps_t decode_lamps(input state_e st, input logic blink);
      lamps_t l;
      l = '{main: LAMP_R, side: LAMP_R, walk: 1'b0};
      case (st)
         ST_MAIN_GREEN:  l.main = LAMP_G;
         ST_MAIN_YELLOW: l.main = LAMP_Y;
         ST_SIDE_GREEN: begin
            l.side = LAMP_G;
            l.walk = 1'b1;
         end
         ST_SIDE_YELLOW: l.side = LAMP_Y;
         ST_FLASH: begin
            l.main = blink ? LAMP_Y : LAMP_OFF;
            l.side = blink ? LAMP_R : LAMP_OFF;
         end
         default: ;
      endcase
      return l;
   endfunction

endpackage

// File: rtl/tl_down_counter.sv
// Loadable down counter for state durations; saturates at zero so it can
// never wrap while a state is being held.
module tl_down_counter #(
   parameter int               CNT_W   = 5,
   parameter logic [CNT_W-1:0] RST_VAL = '0
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   input  logic             dec_i,
   output logic [CNT_W-1:0] value_o,
   output logic             zero_o
);

   logic [CNT_W-1:0] value_q, value_d;

   always_comb begin
      value_d = value_q;
      if (load_i)
         value_d = load_val_i;
      else if (dec_i && (value_q != '0))
         value_d = value_q - 1'b1;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) value_q <= RST_VAL;
      else       value_q <= value_d;
   end

   assign value_o = value_q;
   assign zero_o  = (value_q == '0);

endmodule

// File: rtl/traffic_light_fsm.sv
// Main/side road intersection controller with pedestrian early-exit and
// night flash mode; all outputs are registered Moore decodes of next state.
module traffic_light_fsm
   import traffic_pkg::*;
#(
   parameter int G_MAIN = 10,
   parameter int G_SIDE = 6,
   parameter int Y_TIME = 3,
   parameter int R_ALL  = 1,
   parameter int G_MIN  = 4,
   parameter int CNT_W  = 5
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             ped_req_i,
   input  logic             night_i,
   output logic [2:0]       main_light_o,
   output logic [2:0]       side_light_o,
   output logic             ped_walk_o,
   output logic [CNT_W-1:0] remain_o,
   output logic [2:0]       state_o
);

   localparam logic [CNT_W-1:0] LD_MAIN = CNT_W'(G_MAIN - 1);
   localparam logic [CNT_W-1:0] LD_SIDE = CNT_W'(G_SIDE - 1);
   localparam logic [CNT_W-1:0] LD_Y    = CNT_W'(Y_TIME - 1);
   localparam logic [CNT_W-1:0] LD_R    = CNT_W'(R_ALL - 1);
   // Main green has run at least G_MIN ticks once cnt drops to this value.
   localparam logic [CNT_W-1:0] PED_THR = CNT_W'(G_MAIN - G_MIN);

   state_e           state_q, state_d;
   logic             ped_pending_q, ped_pending_d;
   logic             blink_q, blink_d;
   logic [2:0]       main_light_q, side_light_q;
   logic             ped_walk_q;
   logic             cnt_ld, cnt_dec, cnt_zero;
   logic [CNT_W-1:0] cnt_ld_val, cnt;
   logic             ped_set, ped_eff;
   lamps_t           lamps_d;

   tl_down_counter #(.CNT_W(CNT_W), .RST_VAL(LD_MAIN)) u_cnt (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .load_i     (cnt_ld),
      .load_val_i (cnt_ld_val),
      .dec_i      (cnt_dec),
      .value_o    (cnt),
      .zero_o     (cnt_zero)
   );

   assign ped_set = ped_req_i && (state_q != ST_SIDE_GREEN);
   assign ped_eff = ped_pending_q || ped_set;

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_MAIN_GREEN:
            if (night_i || (ped_eff && cnt <= PED_THR) || cnt_zero)
               state_d = ST_MAIN_YELLOW;
         ST_MAIN_YELLOW: if (cnt_zero) state_d = ST_ALL_RED_1;
         ST_ALL_RED_1:   if (cnt_zero) state_d = night_i ? ST_FLASH : ST_SIDE_GREEN;
         ST_SIDE_GREEN:  if (night_i || cnt_zero) state_d = ST_SIDE_YELLOW;
         ST_SIDE_YELLOW: if (cnt_zero) state_d = ST_ALL_RED_2;
         ST_ALL_RED_2:   if (cnt_zero) state_d = night_i ? ST_FLASH : ST_MAIN_GREEN;
         ST_FLASH:       if (!night_i) state_d = ST_ALL_RED_2;
         default:        state_d = ST_ALL_RED_2;
      endcase

      // Any state change (including illegal-encoding recovery) reloads the timer.
      cnt_ld  = (state_d != state_q);
      cnt_dec = !cnt_ld;
      case (state_d)
         ST_MAIN_GREEN:                 cnt_ld_val = LD_MAIN;
         ST_SIDE_GREEN:                 cnt_ld_val = LD_SIDE;
         ST_MAIN_YELLOW, ST_SIDE_YELLOW: cnt_ld_val = LD_Y;
         ST_ALL_RED_1, ST_ALL_RED_2:    cnt_ld_val = LD_R;
         default:                       cnt_ld_val = '0;
      endcase

      ped_pending_d = ped_pending_q;
      if (state_d == ST_SIDE_GREEN && state_q != ST_SIDE_GREEN)
         ped_pending_d = 1'b0;
      else if (ped_set)
         ped_pending_d = 1'b1;

      blink_d = 1'b0;
      if (state_d == ST_FLASH)
         blink_d = (state_q == ST_FLASH) ? ~blink_q : 1'b1;

      lamps_d = decode_lamps(state_d, blink_d);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q       <= ST_MAIN_GREEN;
         ped_pending_q <= 1'b0;
         blink_q       <= 1'b0;
         main_light_q  <= LAMP_G;
         side_light_q  <= LAMP_R;
         ped_walk_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         ped_pending_q <= ped_pending_d;
         blink_q       <= blink_d;
         main_light_q  <= lamps_d.main;
         side_light_q  <= lamps_d.side;
         ped_walk_q    <= lamps_d.walk;
      end
   end

   assign main_light_o = main_light_q;
   assign side_light_o = side_light_q;
   assign ped_walk_o   = ped_walk_q;
   assign remain_o     = cnt;
   assign state_o      = state_q;

endmodule
